restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 13 +
 rtl/restoring_divider_sub_nbit.sv | 42 ++++
 rtl/restoring_divider.sv | 118 +++++++++++
 tb/tb_restoring_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state type and the
// default operand width.
package restoring_divider_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider_sub_nbit.sv
// Combinational N-bit carry-lookahead subtractor: diff = a + ~b + 1.
// borrow is the inverted carry out of the top bit (set when a < b).
module sub_nbit #(
   parameter int unsigned N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N:0]   carry;
   logic         acc;
   logic         pchain;

   assign gen  = a & ~b;
   assign prop = a ^ ~b;

   // Each carry is expanded directly from generate/propagate terms and the
   // +1 carry-in, so no carry depends on another carry.
   always_comb begin
      carry    = '0;
      acc      = 1'b0;
      pchain   = 1'b1;
      carry[0] = 1'b1;
      for (int unsigned i = 1; i <= N; i++) begin
         acc    = 1'b0;
         pchain = 1'b1;
         for (int unsigned k = 0; k < i; k++) begin
            acc    = acc | (pchain & gen[i-1-k]);
            pchain = pchain & prop[i-1-k];
         end
         carry[i] = acc | pchain;
      end
   end

   assign diff   = prop ^ carry[N-1:0];
   assign borrow = ~carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_CHECK_EN: a zero divisor finishes in the
// accepting edge and raises div_by_zero; otherwise it runs all WIDTH
// iterations (which naturally yield all-ones / dividend) and div_by_zero
// stays 0.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic             unused_trial_msb;

   // {R,Q} shifted left by one; R widened by one bit so the trial
   // subtraction cannot overflow.
   assign r_shift = {r_reg, q_reg[WIDTH-1]};

   sub_nbit #(
      .N(WIDTH + 1)
   ) u_sub (
      .a     (r_shift),
      .b     ({1'b0, d_reg}),
      .diff  (trial),
      .borrow(borrow)
   );

   // A successful trial is always below the divisor, so its top bit is zero.
   assign unused_trial_msb = trial[WIDTH];
   assign r_next = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_next = {q_reg[WIDTH-2:0], ~borrow};

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef DIVIDER_ZERO_CHECK_EN
   logic zero_flag;
   assign div_by_zero = zero_flag;
`else
   assign div_by_zero = 1'b0;
`endif

   // Sequencing: accept in IDLE/DONE, iterate in RUN, publish results on DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         r_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         count     <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
         zero_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  d_reg <= divisor;
                  r_reg <= '0;
                  q_reg <= dividend;
                  count <= CW'(WIDTH);
                  state <= RUN;
`ifdef DIVIDER_ZERO_CHECK_EN
                  if (divisor == '0) begin
                     state     <= DONE;
                     quotient  <= '1;
                     remainder <= dividend;
                     zero_flag <= 1'b1;
                  end
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state     <= DONE;
                  quotient  <= q_next;
                  remainder <= r_next;
`ifdef DIVIDER_ZERO_CHECK_EN
                  zero_flag <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=8): the driver pushes the
// expected quotient/remainder/flag and completion cycle per accepted start;
// a monitor pops and compares on every done pulse.
module tb_restoring_divider;

   localparam int unsigned W = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   restoring_divider #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called on a negedge; returns on the negedge after the sampling edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (track) begin
         if (b == '0) begin
            e.q = '1;
            e.r = a;
         end else begin
            e.q = a / b;
            e.r = a % b;
         end
         e.z   = ZC && (b == '0);
         e.cyc = cyc + 1 + ((ZC && (b == '0)) ? 0 : int'(W));
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, done, 1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("quotient", quotient, mon_e.q);
            check("remainder", remainder, mon_e.r);
            check("div_by_zero", div_by_zero, mon_e.z);
            check("done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [W-1:0] va[4] = '{8'd255, 8'd5, 8'd255, 8'd200};
   logic [W-1:0] vb[4] = '{8'd1,   8'd9, 8'd255, 8'd0};

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);

      // Release and start on the very first edge.
      rst = 1'b0;
      issue(8'd100, 8'd7, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("busy_run", busy, 1);
         check("done_early", done, 0);
         @(negedge clk);
      end
      check("busy_at_done", busy, 0);
      wait_done("done_100_7");
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);

      // Value and boundary cases, including divide by zero.
      for (int i = 0; i < 4; i++) begin
         issue(va[i], vb[i], 1'b1);
         if (vb[i] == '0 && ZC) check("zero_busy", busy, 0);
         wait_done("done_table");
         @(negedge clk);
      end

      // Start during RUN is ignored; start during DONE is accepted.
      issue(8'd100, 8'd7, 1'b1);
      repeat (2) @(negedge clk);
      issue(8'd50, 8'd5, 1'b0);
      wait_done("done_ignored");
      issue(8'd50, 8'd5, 1'b1);
      wait_done("done_b2b");
      @(negedge clk);

      // Reset mid-run aborts; no done pulse may follow.
      issue(8'd100, 8'd7, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(8'd9, 8'd2, 1'b1);
      wait_done("done_9_2");
      @(negedge clk);

      // Random back-to-back sweep.
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         int unsigned  sel;
         a   = W'($urandom);
         sel = $urandom_range(0, 15);
         if (sel == 0)      b = '0;
         else if (sel < 4)  b = W'(sel);
         else               b = W'($urandom);
         issue(a, b, 1'b1);
         wait_done("done_rand");
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
